// File: rtl/mul8_nibble_sequencer.sv
// mul8_nibble_sequencer: unsigned 8x8->16 multiply on one shared 4x4 core, four nibble steps
// Optional multiply-accumulate when MUL8_ACC_EN is defined.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start_valid/start_ready operand handshake carrying a, b and acc_clr
//   res_valid/res_ready     result handshake carrying res
//   ovf                     sticky accumulate overflow (0 without MUL8_ACC_EN)
//   busy                    high whenever not idle
module mul8_nibble_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        acc_clr,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res,
    output logic        ovf,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic        ovf_q, ovf_d;
    logic [3:0]  na, nb, sh;
    logic [7:0]  pp;
    logic [16:0] sum;
    logic        accept;
    // step[1] picks the a nibble, step[0] the b nibble, giving lo*lo, lo*hi, hi*lo, hi*hi
    always_comb begin
        na  = step_q[1] ? a_q[7:4] : a_q[3:0];
        nb  = step_q[0] ? b_q[7:4] : b_q[3:0];
        pp  = {4'b0, na} * {4'b0, nb};
        sh  = (step_q == 2'd0) ? 4'd0 : (step_q == 2'd3) ? 4'd8 : 4'd4;
        sum = {1'b0, acc_q} + ({9'b0, pp} << sh);
    end
    assign accept = start_valid && state_q == IDLE;
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = MUL;
                step_d  = 2'd0;
                a_d     = a;
                b_d     = b;
`ifdef MUL8_ACC_EN
                acc_d   = acc_clr ? 16'd0 : acc_q;
                ovf_d   = acc_clr ? 1'b0 : ovf_q;
`else
                acc_d   = 16'd0;
`endif
            end
            MUL: begin
                acc_d   = sum[15:0];
`ifdef MUL8_ACC_EN
                ovf_d   = ovf_q | sum[16];
`endif
                step_d  = step_q + 2'd1;
                state_d = (step_q == 2'd3) ? DONE : MUL;
            end
            DONE: state_d = res_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
`ifndef MUL8_ACC_EN
    // without accumulation the clear flag and the final carry have no consumer
    logic unused_bits;
    assign unused_bits = acc_clr ^ sum[16];
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= 2'd0;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
            acc_q   <= 16'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end
    assign start_ready = state_q == IDLE;
    assign res_valid   = state_q == DONE;
    assign busy        = state_q != IDLE;
    assign res         = acc_q;
    assign ovf         = ovf_q;
endmodule

// File: tb/tb_mul8_nibble_sequencer.sv
// tb_mul8_nibble_sequencer: directed self-checking bench for mul8_nibble_sequencer
module tb_mul8_nibble_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [7:0]  a = 8'd0;
    logic [7:0]  b = 8'd0;
    logic        acc_clr = 1'b1;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res;
    logic        ovf;
    logic        busy;
    int          checks = 0;
    int          failures = 0;

    mul8_nibble_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b), .acc_clr(acc_clr), .res_valid(res_valid), .res_ready(res_ready),
        .res(res), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept_op(input logic [7:0] x, input logic [7:0] y, input logic clr);
        a = x;
        b = y;
        acc_clr = clr;
        start_valid = 1'b1;
        check("ready_before_accept", start_ready, 1);
        tick();
        start_valid = 1'b0;
        a = 8'hC3;
        b = 8'h3C;
    endtask

    task automatic run(input string tag, input logic [7:0] x, input logic [7:0] y, input logic clr,
                       input logic [15:0] exp, input logic exp_ovf);
        accept_op(x, y, clr);
        for (int i = 1; i <= 4; i++) begin
            check({tag, "_busy_mul"}, busy, 1);
            check({tag, "_novalid_mul"}, res_valid, 0);
            tick();
        end
        check({tag, "_valid_n5"}, res_valid, 1);
        check({tag, "_res"}, res, exp);
        check({tag, "_ovf"}, ovf, exp_ovf);
        check({tag, "_busy_done"}, busy, 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_idle_valid"}, res_valid, 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        tick();
        tick();
        check("rst_ready", start_ready, 1);
        check("rst_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        check("rst_res", res, 0);
        rst_n = 1'b1;
        tick();

        run("ff_ff", 8'hFF, 8'hFF, 1'b1, 16'hFE01, 1'b0);
        run("12_34", 8'h12, 8'h34, 1'b1, 16'h03A8, 1'b0);
        run("00_a7", 8'h00, 8'hA7, 1'b1, 16'h0000, 1'b0);
        run("80_02", 8'h80, 8'h02, 1'b1, 16'h0100, 1'b0);

        // hold res_ready low in DONE
        accept_op(8'h0A, 8'h0B, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", res_valid, 1);
            check("hold_res", res, 16'h006E);
            check("hold_ready", start_ready, 0);
            tick();
        end
        check("hold_res_last", res, 16'h006E);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("hold_idle_ready", start_ready, 1);
        check("hold_idle_valid", res_valid, 0);

        // start_valid during MUL must be ignored
        accept_op(8'h12, 8'h34, 1'b1);
        tick();
        a = 8'h55;
        b = 8'h55;
        start_valid = 1'b1;
        check("intr_ready_mul", start_ready, 0);
        tick();
        check("intr_ready_mul2", start_ready, 0);
        start_valid = 1'b0;
        tick();
        tick();
        check("intr_valid", res_valid, 1);
        check("intr_res", res, 16'h03A8);
        check("intr_ready_done", start_ready, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("intr_idle", start_ready, 1);

        // asynchronous reset during step2 aborts the operation
        accept_op(8'hFF, 8'hFF, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_ready", start_ready, 1);
        check("arst_valid", res_valid, 0);
        check("arst_res", res, 0);
        check("arst_ovf", ovf, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("arst_no_valid", res_valid, 0);
        end
        run("0f_0f", 8'h0F, 8'h0F, 1'b1, 16'h00E1, 1'b0);

`ifdef MUL8_ACC_EN
        run("mac_clr", 8'h10, 8'h10, 1'b1, 16'h0100, 1'b0);
        run("mac_add1", 8'hFF, 8'hFF, 1'b0, 16'hFF01, 1'b0);
        run("mac_add2", 8'hFF, 8'hFF, 1'b0, 16'hFD02, 1'b1);
        check("mac_ovf_sticky", ovf, 1);
        run("mac_clr2", 8'h01, 8'h01, 1'b1, 16'h0001, 1'b0);
`else
        run("noacc_clr0_a", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0);
        run("noacc_clr0_b", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
